usb_reg_bridge: RTL and testbench
=================================

# usb_reg_bridge

Parametrised successor to the CW305 USB-to-register adapter, between the FPGA USB parallel interface (address, data, strobes) and the register file in the user design. It runs a strobe FSM that turns level strobes into single-cycle `reg_read`/`reg_write` pulses and registers read return data. It adds a configurable read-return pipeline and an optional burst mode: address latched on `usb_alen`, byte count auto-incremented per access.

## Interface
- `pADDR_WIDTH`, default 21: USB address width.
- `pBYTECNT_SIZE`, default 7: low address bits selecting the byte within a register.
- `pREG_RDDLY_LEN`, default 3, minimum 1: cycles `usb_isout` stays high after a read strobe releases.
- `usb_clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `usb_din`  in  8: write data from host.
- `usb_dout`  out  8: registered read data to host.
- `usb_isout`  out  1: data bus direction; 1 = FPGA drives.
- `usb_addr`  in  pADDR_WIDTH: host address.
- `usb_rdn`, `usb_wrn`, `usb_cen`  in  1 each: active-low read strobe, write strobe and chip enable.
- `usb_alen`  in  1: active-low address latch enable; used only in burst mode.
- `reg_address`  out  pADDR_WIDTH-pBYTECNT_SIZE: register select.
- `reg_bytecnt`  out  pBYTECNT_SIZE: byte within register.
- `reg_datao`  out  8: write data; holds until the next write.
- `reg_datai`  in  8: read data from the register file.
- `reg_read`  out  1: one-cycle read pulse.
- `reg_write`  out  1: one-cycle write pulse.
- `reg_addrvalid`  out  1: address valid.

## Operation
- **Input stage:** `usb_addr`, `usb_din`, `usb_rdn`, `usb_wrn`, `usb_cen` and `usb_alen` are registered once (stage S1). All decisions use S1 values.
- **Strobe definitions:** `rd_act = ~cen_r & ~rdn_r`; `wr_act = ~cen_r & ~wrn_r`.
- **FSM states:** IDLE, RD, WR, WAIT.
  - IDLE → RD on `rd_act & ~wr_act`.
  - IDLE → WR on `wr_act & ~rd_act`.
  - IDLE → WAIT on `rd_act & wr_act`, which is illegal; no pulse is issued.
  - RD → IDLE when `~rd_act`. WR → IDLE when `~wr_act`.
  - WAIT → IDLE when `~rd_act & ~wr_act`.
- **Pulses:**
  - `reg_read` = 1 only for the cycle after entry to RD.
  - `reg_write` = 1 only for the cycle after entry to WR.
  - `reg_datao` loads S1 `din` on the same edge that raises `reg_write`.
- **Read return:** `usb_dout` loads `reg_datai` on the edge that ends the `reg_read` cycle, then holds.
- **usb_isout:** = (state==RD) OR any bit of a `pREG_RDDLY_LEN`-bit shift register fed with (state==RD).
- **Reset:** all outputs and registers go to 0; state goes to WAIT. A strobe still asserted when reset deasserts produces no pulse until it is released and reasserted.

## Timing
- Host strobe sampled at edge E1 (into S1). FSM changes state at E2. `reg_read`/`reg_write` high during E2–E3.
- `reg_datai` must be valid at E3. `usb_dout` is valid from E3.
- `usb_isout` rises at E2. It falls `pREG_RDDLY_LEN` cycles after the FSM leaves RD.
- Minimum strobe width: 2 cycles for a pulse. Back-to-back accesses need at least 1 cycle of deasserted S1 strobe between them.
- `usb_cen` deasserted mid-strobe counts as strobe release.

## Configuration
- `USB_REG_BURST_EN` defined:
  - When `~alen_r` is seen in IDLE: `reg_address`/`reg_bytecnt` load from `addr_r` and `reg_addrvalid` is set to 1.
  - On each RD→IDLE or WR→IDLE transition, `reg_bytecnt` increments by 1, wrapping from 2^pBYTECNT_SIZE−1 to 0. `reg_address` is unchanged.
  - If `~alen_r` coincides with a transition, the latch wins and no increment occurs.
  - WAIT exits never increment.
- `USB_REG_BURST_EN` undefined:
  - `reg_address`/`reg_bytecnt` follow S1 `addr_r` every cycle.
  - `reg_addrvalid` is 1 from the first cycle after reset.
  - `usb_alen` is ignored.

## Test plan
- Write `usb_addr`=0x000105, `usb_din`=0xA5, `usb_wrn` low for 4 cycles → exactly one `reg_write` pulse 2 cycles after the strobe; `reg_datao`=0xA5, `reg_address`=0x2, `reg_bytecnt`=0x05.
- Read with `reg_datai`=0x3C → one `reg_read` pulse; `usb_dout`=0x3C one cycle later. `usb_isout` high from E2 until 3 cycles after release (default parameters).
- `usb_rdn` and `usb_wrn` low together → no pulses; FSM in WAIT until both high. A subsequent read behaves normally.
- `reset` asserted during an active read with `usb_rdn` held low afterwards → outputs 0, no `reg_read` until `usb_rdn` goes high then low again.
- Burst mode: `usb_alen` latch with `usb_addr`=0x00017F, then 3 writes → `reg_bytecnt` 0x7F, 0x00, 0x01; `reg_address` stays 0x2.
- Non-burst mode: `usb_addr` changes each cycle with `usb_alen` idle → `reg_address`/`reg_bytecnt` track with 1-cycle latency; `reg_addrvalid`=1.

Source files
------------

// File: rtl/usb_reg_bridge.sv
// usb_reg_bridge: bridge between the FPGA USB parallel bus (address, data,
// active-low strobes) and a byte-wide register file. Level strobes become
// single-cycle reg_read / reg_write pulses and read data is registered back
// to the host. usb_isout is stretched by a short pipeline after each read.
//
// Build option: define USB_REG_BURST_EN to latch the address on usb_alen and
// auto-increment reg_bytecnt after every completed read or write. Without it
// the register address follows the registered host address every cycle.
module usb_reg_bridge #(
    parameter int pADDR_WIDTH    = 21,
    parameter int pBYTECNT_SIZE  = 7,
    parameter int pREG_RDDLY_LEN = 3
) (
    input  logic                                   usb_clk,
    input  logic                                   reset,
    input  logic [7:0]                             usb_din,
    output logic [7:0]                             usb_dout,
    output logic                                   usb_isout,
    input  logic [pADDR_WIDTH-1:0]                 usb_addr,
    input  logic                                   usb_rdn,
    input  logic                                   usb_wrn,
    input  logic                                   usb_cen,
    input  logic                                   usb_alen,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
    output logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
    output logic [7:0]                             reg_datao,
    input  logic [7:0]                             reg_datai,
    output logic                                   reg_read,
    output logic                                   reg_write,
    output logic                                   reg_addrvalid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    // Registered (S1) copies of the host bus; every decision uses these.
    logic [pADDR_WIDTH-1:0] addr_r;
    logic [7:0]             din_r;
    logic                   rdn_r;
    logic                   wrn_r;
    logic                   cen_r;

    logic                   rd_act;
    logic                   wr_act;

    state_t                 state;
    state_t                 state_nxt;
    logic                   rd_start;
    logic                   wr_start;

    logic [pREG_RDDLY_LEN-1:0] rd_dly;

    // Input stage: sample host bus once before any decoding.
    // NOTE: the strobe copies reset to 0, which reads as "read and write both
    // active"; together with the WAIT reset state this blocks any pulse until
    // the host has released its strobes after reset.
    always_ff @(posedge usb_clk) begin
        if (reset) begin
            addr_r <= '0;
            din_r  <= '0;
            rdn_r  <= 1'b0;
            wrn_r  <= 1'b0;
            cen_r  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            addr_r <= usb_addr;
            din_r  <= usb_din;
            rdn_r  <= usb_rdn;
            wrn_r  <= usb_wrn;
            cen_r  <= usb_cen;
        end
    end

    // A strobe only counts while chip enable is low.
    assign rd_act = ~cen_r & ~rdn_r;
    assign wr_act = ~cen_r & ~wrn_r;

    // Strobe FSM state register.
    always_ff @(posedge usb_clk) begin
        if (reset) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobe FSM next-state and access-start decode.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        rd_start  = 1'b0;
        wr_start  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rd_act && !wr_act) begin
                    state_nxt = ST_RD;
                    rd_start  = 1'b1;
                end else if (wr_act && !rd_act) begin
                    state_nxt = ST_WR;
                    wr_start  = 1'b1;
                end else if (rd_act && wr_act) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_RD: begin
                if (!rd_act) state_nxt = ST_IDLE;
            end
            ST_WR: begin
                if (!wr_act) state_nxt = ST_IDLE;
            end
            ST_WAIT: begin
                if (!rd_act && !wr_act) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

    // Access pulses, write-data capture and read-data return.
    always_ff @(posedge usb_clk) begin
        if (reset) begin
            reg_read  <= 1'b0;
            reg_write <= 1'b0;
            reg_datao <= '0;
            usb_dout  <= '0;
        end else begin
            reg_read  <= rd_start;
            reg_write <= wr_start;
            if (wr_start) begin
                reg_datao <= din_r;
            end
            if (reg_read) begin
                usb_dout <= reg_datai;
            end
        end
    end

    // Read-direction stretch: remembers the last cycles spent in RD.
    always_ff @(posedge usb_clk) begin
        if (reset) begin
            rd_dly <= '0;
        end else begin
            rd_dly[0] <= (state == ST_RD);
            for (int i = 1; i < pREG_RDDLY_LEN; i++) begin
                rd_dly[i] <= rd_dly[i-1];
            end
        end
    end

    assign usb_isout = (state == ST_RD) | (|rd_dly);

`ifdef USB_REG_BURST_EN
    localparam logic [pBYTECNT_SIZE-1:0] BYTE_ONE = 1;

    logic alen_r;
    logic bus_done;
    logic addr_latch;

    // Address latch enable gets its own S1 flop in burst mode only.
    always_ff @(posedge usb_clk) begin
        if (reset) begin
            alen_r <= 1'b0;
        end else begin
            alen_r <= usb_alen;
        end
    end

    // A completed read or write returns the FSM to IDLE; WAIT exits do not count.
    assign bus_done   = ((state == ST_RD) & ~rd_act) | ((state == ST_WR) & ~wr_act);
    // A latch request in IDLE, or on the same edge as a completion, takes priority.
    assign addr_latch = ~alen_r & ((state == ST_IDLE) | bus_done);

    // Burst address register: load on latch, step the byte count per access.
    always_ff @(posedge usb_clk) begin
        if (reset) begin
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            reg_addrvalid <= 1'b0;
        end else if (addr_latch) begin
            reg_address   <= addr_r[pADDR_WIDTH-1:pBYTECNT_SIZE];
            reg_bytecnt   <= addr_r[pBYTECNT_SIZE-1:0];
            reg_addrvalid <= 1'b1;
        end else if (bus_done) begin
            reg_bytecnt   <= reg_bytecnt + BYTE_ONE;
        end
    end
`else
    logic alen_unused;

    // Address latch enable has no meaning without burst mode.
    assign alen_unused = usb_alen;

    // Register address tracks the sampled host address directly.
    assign reg_address = addr_r[pADDR_WIDTH-1:pBYTECNT_SIZE];
    assign reg_bytecnt = addr_r[pBYTECNT_SIZE-1:0];

    // Address is valid from the first cycle out of reset.
    always_ff @(posedge usb_clk) begin
        if (reset) begin
            reg_addrvalid <= 1'b0;
        end else begin
            reg_addrvalid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_usb_reg_bridge.sv
// tb_usb_reg_bridge: directed self-checking bench for usb_reg_bridge with
// default parameters. Inputs change 1 time unit after a rising edge and
// outputs are checked there too, away from the active edge.
// Burst checks are compiled in when USB_REG_BURST_EN is defined.
module tb_usb_reg_bridge;

    logic        usb_clk;
    logic        reset;
    logic [7:0]  usb_din;
    logic [7:0]  usb_dout;
    logic        usb_isout;
    logic [20:0] usb_addr;
    logic        usb_rdn;
    logic        usb_wrn;
    logic        usb_cen;
    logic        usb_alen;
    logic [13:0] reg_address;
    logic [6:0]  reg_bytecnt;
    logic [7:0]  reg_datao;
    logic [7:0]  reg_datai;
    logic        reg_read;
    logic        reg_write;
    logic        reg_addrvalid;

    int n_checks = 0;
    int n_errors = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;

    usb_reg_bridge dut (
        .usb_clk       (usb_clk),
        .reset         (reset),
        .usb_din       (usb_din),
        .usb_dout      (usb_dout),
        .usb_isout     (usb_isout),
        .usb_addr      (usb_addr),
        .usb_rdn       (usb_rdn),
        .usb_wrn       (usb_wrn),
        .usb_cen       (usb_cen),
        .usb_alen      (usb_alen),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .reg_datao     (reg_datao),
        .reg_datai     (reg_datai),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_addrvalid (reg_addrvalid)
    );

    initial usb_clk = 1'b0;
    always #5 usb_clk = ~usb_clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge usb_clk) begin
        if (reg_read === 1'b1)  rd_pulses++;
        if (reg_write === 1'b1) wr_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge usb_clk);
        #1;
    endtask

`ifndef USB_REG_BURST_EN
    logic [20:0] trk_addr [4] = '{21'h1FFFFF, 21'h000080, 21'h012345, 21'h00007F};
    logic [13:0] trk_reg  [4] = '{14'h3FFF,   14'h0001,   14'h0246,   14'h0000};
    logic [6:0]  trk_byte [4] = '{7'h7F,      7'h00,      7'h45,      7'h7F};
`else
    logic [6:0]  burst_byte [3] = '{7'h7F, 7'h00, 7'h01};
`endif

    initial begin
        reset     = 1'b1;
        usb_din   = 8'h00;
        usb_addr  = 21'h0;
        usb_rdn   = 1'b1;
        usb_wrn   = 1'b1;
        usb_cen   = 1'b0;
        usb_alen  = 1'b1;
        reg_datai = 8'h00;

        // Reset state
        cyc(3);
        check("rst_dout",      usb_dout, 8'h00);
        check("rst_isout",     usb_isout, 1'b0);
        check("rst_read",      reg_read, 1'b0);
        check("rst_write",     reg_write, 1'b0);
        check("rst_datao",     reg_datao, 8'h00);
        check("rst_addrvalid", reg_addrvalid, 1'b0);
        reset = 1'b0;
        cyc(3);

        // Single write, strobe held 4 cycles
        wr_pulses = 0;
        usb_addr  = 21'h000105;
        usb_din   = 8'hA5;
        usb_wrn   = 1'b0;
        cyc(1);
        check("wr_early", reg_write, 1'b0);
        cyc(1);
        check("wr_pulse", reg_write, 1'b1);
        check("wr_datao", reg_datao, 8'hA5);
`ifndef USB_REG_BURST_EN
        check("wr_addr",      reg_address, 14'h0002);
        check("wr_bytecnt",   reg_bytecnt, 7'h05);
        check("wr_addrvalid", reg_addrvalid, 1'b1);
`endif
        cyc(1);
        check("wr_pulse_end", reg_write, 1'b0);
        cyc(1);
        usb_wrn = 1'b1;
        usb_din = 8'h00;
        cyc(4);
        check("wr_count",      wr_pulses, 1);
        check("wr_datao_hold", reg_datao, 8'hA5);

        // Single read with return data and direction stretch
        rd_pulses = 0;
        reg_datai = 8'h3C;
        usb_rdn   = 1'b0;
        cyc(1);
        check("rd_isout_pre", usb_isout, 1'b0);
        cyc(1);
        check("rd_pulse", reg_read, 1'b1);
        check("rd_isout", usb_isout, 1'b1);
        cyc(1);
        check("rd_pulse_end", reg_read, 1'b0);
        check("rd_dout",      usb_dout, 8'h3C);
        usb_rdn   = 1'b1;
        reg_datai = 8'h77;
        cyc(2);
        check("rd_isout_leave", usb_isout, 1'b1);
        cyc(2);
        check("rd_isout_last", usb_isout, 1'b1);
        cyc(1);
        check("rd_isout_fall", usb_isout, 1'b0);
        check("rd_dout_hold",  usb_dout, 8'h3C);
        check("rd_count",      rd_pulses, 1);

        // Read and write strobes together: no pulse, stuck until both release
        rd_pulses = 0;
        wr_pulses = 0;
        usb_rdn   = 1'b0;
        usb_wrn   = 1'b0;
        cyc(2);
        check("both_read",  reg_read, 1'b0);
        check("both_write", reg_write, 1'b0);
        check("both_isout", usb_isout, 1'b0);
        cyc(2);
        usb_rdn = 1'b1;
        cyc(3);
        check("both_wr_only_count", wr_pulses, 0);
        check("both_rd_count",      rd_pulses, 0);
        usb_wrn = 1'b1;
        cyc(2);
        reg_datai = 8'h5A;
        usb_rdn   = 1'b0;
        cyc(2);
        check("after_wait_read", reg_read, 1'b1);
        cyc(1);
        check("after_wait_dout", usb_dout, 8'h5A);
        usb_rdn = 1'b1;
        cyc(6);
        check("after_wait_count", rd_pulses, 1);

        // Reset in the middle of a read, strobe held through reset
        reg_datai = 8'h96;
        usb_rdn   = 1'b0;
        cyc(2);
        check("mid_read_pulse", reg_read, 1'b1);
        reset = 1'b1;
        cyc(2);
        rd_pulses = 0;
        check("mid_rst_dout",      usb_dout, 8'h00);
        check("mid_rst_isout",     usb_isout, 1'b0);
        check("mid_rst_datao",     reg_datao, 8'h00);
        check("mid_rst_read",      reg_read, 1'b0);
        check("mid_rst_addrvalid", reg_addrvalid, 1'b0);
        reset = 1'b0;
        cyc(5);
        check("held_rd_count", rd_pulses, 0);
        check("held_rd_isout", usb_isout, 1'b0);
        usb_rdn = 1'b1;
        cyc(2);
        usb_rdn = 1'b0;
        cyc(2);
        check("reread_pulse", reg_read, 1'b1);
        cyc(1);
        check("reread_dout", usb_dout, 8'h96);
        usb_rdn = 1'b1;
        cyc(6);
        check("reread_count", rd_pulses, 1);

`ifndef USB_REG_BURST_EN
        // Address tracking with one cycle of latency, usb_alen idle
        usb_addr = 21'h000000;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            usb_addr = trk_addr[i];
            check("trk_addr_before", reg_address, (i == 0) ? 14'h0000 : trk_reg[i-1]);
            cyc(1);
            check("trk_addr",    reg_address, trk_reg[i]);
            check("trk_bytecnt", reg_bytecnt, trk_byte[i]);
        end
        check("trk_addrvalid", reg_addrvalid, 1'b1);
`else
        // Burst: latch 0x00017F then three writes stepping the byte count
        usb_addr = 21'h00017F;
        usb_alen = 1'b0;
        cyc(1);
        usb_alen = 1'b0;
        usb_alen = 1'b1;
        usb_addr = 21'h000000;
        cyc(1);
        check("burst_latch_addr",  reg_address, 14'h0002);
        check("burst_latch_byte",  reg_bytecnt, 7'h7F);
        check("burst_latch_valid", reg_addrvalid, 1'b1);
        for (int k = 0; k < 3; k++) begin
            usb_din = 8'h10 + 8'(k);
            usb_wrn = 1'b0;
            cyc(2);
            check("burst_wr_pulse", reg_write, 1'b1);
            check("burst_wr_byte",  reg_bytecnt, burst_byte[k]);
            check("burst_wr_addr",  reg_address, 14'h0002);
            cyc(1);
            usb_wrn = 1'b1;
            cyc(3);
        end
        check("burst_final_byte", reg_bytecnt, 7'h02);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
